four_bit_seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider; the inverse arithmetic path to the ripple adder.

---
 rtl/alsu_pkg.sv | 18 +
 rtl/div_trial_sub.sv | 25 ++
 rtl/four_bit_seq_divider.sv | 135 +++++++++++++
 tb/tb_four_bit_seq_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU datapath: default operand width,
// divider state encoding and the full-adder cell used by the subtractor.
package alsu_pkg;

   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // One full-adder cell; returns {carry_out, sum}.
   function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
      full_adder = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
   endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for the restoring divider: a ripple of full-adder cells
// computing minuend - subtrahend as minuend + ~subtrahend + 1.
// no_borrow is the final carry out (1 when minuend >= subtrahend).
module div_trial_sub
   import alsu_pkg::*;
#(
   parameter int W = DIV_WIDTH + 1
) (
   input  logic [W-1:0] minuend,
   input  logic [W-1:0] subtrahend,
   output logic [W-1:0] difference,
   output logic         no_borrow
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_cell
      assign {carry[i+1], difference[i]} = full_adder(minuend[i], ~subtrahend[i], carry[i]);
   end

   assign no_borrow = carry[W];

endmodule

// File: rtl/four_bit_seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Handshake: start is sampled only in IDLE or DONE; a sampled start captures
// dividend/divisor and begins a new division. busy is high for the RUN cycles,
// done pulses for one cycle when quotient/remainder/div_by_zero become valid.
// Results hold until the next accepted start completes. start during RUN is
// dropped, not queued.
module four_bit_seq_divider
   import alsu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   div_state_e       state;
   div_state_e       state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] p_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] div_reg;

   logic             accept;
   logic             divisor_zero;
   logic             last_step;
   logic [WIDTH:0]   trial_diff;
   logic             no_borrow;
   logic [WIDTH-1:0] p_step;
   logic [WIDTH-1:0] q_step;
   // A successful trial always leaves a partial remainder below the divisor,
   // so the top difference bit is zero whenever it would be kept.
   logic             unused_diff_msb;

   assign accept       = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign divisor_zero = (divisor == '0);
   assign last_step    = (count == '0);

   div_trial_sub #(
      .W (WIDTH + 1)
   ) u_trial (
      .minuend    ({p_reg, q_reg[WIDTH-1]}),
      .subtrahend ({1'b0, div_reg}),
      .difference (trial_diff),
      .no_borrow  (no_borrow)
   );

   assign unused_diff_msb = trial_diff[WIDTH];
   assign p_step = no_borrow ? trial_diff[WIDTH-1:0] : {p_reg[WIDTH-2:0], q_reg[WIDTH-1]};
   assign q_step = {q_reg[WIDTH-2:0], no_borrow};

   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an accepted start in DONE chains straight into the next job.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = divisor_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_step) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nxt = divisor_zero ? ST_DONE : ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, one shift/subtract step per RUN cycle, result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         p_reg       <= '0;
         q_reg       <= '0;
         div_reg     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         div_reg <= divisor;
         if (divisor_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            count <= CW'(WIDTH - 1);
            p_reg <= '0;
            q_reg <= dividend;
         end
      end else if (state == ST_RUN) begin
         p_reg <= p_step;
         q_reg <= q_step;
         if (last_step) begin
            quotient    <= q_step;
            remainder   <= p_step;
            div_by_zero <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Bench for four_bit_seq_divider: directed scenarios plus an exhaustive
// operand sweep, with a queue-based scoreboard fed at issue time and a
// monitor that pops on every done pulse.
module tb_four_bit_seq_divider;

  localparam int W  = 4;
  localparam int EW = 1 + 4 * W;   // {dz, q, r, n, d}

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  four_bit_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            busy_cnt = 0;
  logic [W-1:0]  hold_q = '0;
  logic [W-1:0]  hold_r = '0;
  logic          hold_dz = 1'b0;
  logic [EW-1:0] cur_e;
  int            cur_l;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones quotient,
  // the dividend as remainder and the div_by_zero flag.
  function automatic logic [EW-1:0] model(input int n, input int d);
    logic [W-1:0] nn;
    logic [W-1:0] dd;
    nn = W'(n);
    dd = W'(d);
    if (d == 0) model = {1'b1, {W{1'b1}}, nn, nn, dd};
    else        model = {1'b0, W'(n / d), W'(n % d), nn, dd};
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge while the DUT is in IDLE or DONE.
  task automatic issue(input int n, input int d);
    start    = 1'b1;
    dividend = W'(n);
    divisor  = W'(d);
    exp_q.push_back(model(n, d));
    lat_q.push_back(cyc + 1 + ((d == 0) ? 0 : W));
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Returns #1 after the edge that raised done, or records a timeout.
  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q  = '0;
      hold_r  = '0;
      hold_dz = 1'b0;
    end else if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        cur_e = exp_q.pop_front();
        cur_l = lat_q.pop_front();
        check("quotient", int'(quotient), int'(cur_e[4*W-1:3*W]));
        check("remainder", int'(remainder), int'(cur_e[3*W-1:2*W]));
        check("div_by_zero", int'(div_by_zero), int'(cur_e[4*W]));
        check("done_latency", cyc, cur_l);
        if (!cur_e[4*W]) begin
          check("q_times_d_plus_r", int'(quotient) * int'(cur_e[W-1:0]) + int'(remainder),
                int'(cur_e[2*W-1:W]));
          check("r_lt_d", int'(remainder < cur_e[W-1:0]), 1);
        end
        hold_q  = cur_e[4*W-1:3*W];
        hold_r  = cur_e[3*W-1:2*W];
        hold_dz = cur_e[4*W];
      end
    end else if (busy === 1'b1) begin
      busy_cnt++;
      check("hold_quotient", int'(quotient), int'(hold_q));
      check("hold_remainder", int'(remainder), int'(hold_r));
      check("hold_dz", int'(div_by_zero), int'(hold_dz));
    end
  end

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dz", int'(div_by_zero), 0);
    check("rst_state", int'(state_dbg), 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // 13 / 3 from IDLE
    busy_cnt = 0;
    issue(13, 3);
    wait_done(W + 4);
    check("busy_cycles_13_3", busy_cnt, W);
    step();
    check("done_single_pulse", int'(done), 0);
    check("q_held_after_done", int'(quotient), 4);
    check("r_held_after_done", int'(remainder), 1);

    // back-to-back: second start in the DONE cycle
    issue(15, 1);
    wait_done(W + 4);
    issue(5, 7);
    wait_done(W + 4);
    step();

    // divide by zero: straight to DONE, never busy
    busy_cnt = 0;
    issue(9, 0);
    wait_done(3);
    check("busy_cycles_dz", busy_cnt, 0);
    step();

    // start pulsed during RUN is ignored
    d0 = done_cnt;
    issue(12, 5);
    start    = 1'b1;
    dividend = 4'd2;
    divisor  = 4'd1;
    step();
    start = 1'b0;
    wait_done(W + 4);
    repeat (6) step();
    check("single_done_ignored_start", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);

    // reset in the second RUN cycle aborts the job
    issue(14, 3);
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dz", int'(div_by_zero), 0);
    check("abort_state", int'(state_dbg), 0);
    d0 = done_cnt;
    #1 rst_n = 1'b1;
    repeat (8) step();
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", int'(busy), 0);

    // exhaustive sweep, randomly mixing back-to-back and idle-gap starts
    for (int n = 0; n < (1 << W); n++) begin
      for (int d = 0; d < (1 << W); d++) begin
        issue(n, d);
        wait_done(W + 4);
        if ($urandom_range(0, 1) == 1) step();
      end
    end

    // random operands, random gaps
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
      wait_done(W + 4);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
